// File: rtl/simon_key_schedule.sv
// Simon 32/64 key schedule: streams round keys k0..k31, one per unstalled cycle.
// Optional key cache with forward/reverse replay is enabled by SIMON_KS_KEYCACHE_EN.
module simon_key_schedule #(
    parameter int unsigned ROUNDS = 32,
    parameter int unsigned WORD   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4*WORD-1:0] key,
    input  logic              hold,
`ifdef SIMON_KS_KEYCACHE_EN
    input  logic              replay,
    input  logic              reverse,
`endif
    output logic [WORD-1:0]   round_key,
    output logic [4:0]        round_idx,
    output logic              key_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0]      LAST_IDX = 5'(ROUNDS - 1);
    localparam logic [WORD-1:0] C3       = {{(WORD-2){1'b0}}, 2'b11};
    // Leftmost character of the z0 string is bit 61 here, hence the 61-idx lookup.
    localparam logic [61:0]     Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD - n));
    endfunction

    logic [1:0]      state_q, state_d;
    logic [WORD-1:0] w0_q, w1_q, w2_q, w3_q;
    logic [WORD-1:0] w0_d, w1_d, w2_d, w3_d;
    logic [4:0]      idx_q, idx_d;

    logic [WORD-1:0] t, tmp, knew, key_src;
    logic            zbit, at_last, run;
    logic [4:0]      idx_next;

`ifdef SIMON_KS_KEYCACHE_EN
    logic            rep_q, rep_d;
    logic            rev_q, rev_d;
    logic            filled_q, filled_d;
    logic [WORD-1:0] cache_q [ROUNDS];
`endif

    always_comb begin
        zbit = Z0[6'd61 - {1'b0, idx_q}];
        t    = ror(w3_q, 3) ^ w1_q;
        tmp  = t ^ ror(t, 1);
        knew = ~w0_q ^ tmp ^ {{(WORD-1){1'b0}}, zbit} ^ C3;
    end

`ifdef SIMON_KS_KEYCACHE_EN
    always_comb begin
        at_last  = (idx_q == ((rep_q && rev_q) ? 5'd0 : LAST_IDX));
        idx_next = (rep_q && rev_q) ? idx_q - 5'd1 : idx_q + 5'd1;
        key_src  = rep_q ? cache_q[idx_q] : w0_q;
    end
`else
    always_comb begin
        at_last  = (idx_q == LAST_IDX);
        idx_next = idx_q + 5'd1;
        key_src  = w0_q;
    end
`endif

    always_comb begin
        state_d  = state_q;
        w0_d     = w0_q;
        w1_d     = w1_q;
        w2_d     = w2_q;
        w3_d     = w3_q;
        idx_d    = idx_q;
`ifdef SIMON_KS_KEYCACHE_EN
        rep_d    = rep_q;
        rev_d    = rev_q;
        filled_d = filled_q;
`endif
        if (start) begin
            state_d = S_RUN;
            w0_d    = key[WORD-1:0];
            w1_d    = key[2*WORD-1:WORD];
            w2_d    = key[3*WORD-1:2*WORD];
            w3_d    = key[4*WORD-1:3*WORD];
            idx_d   = '0;
`ifdef SIMON_KS_KEYCACHE_EN
            rep_d    = 1'b0;
            rev_d    = 1'b0;
            filled_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
`ifdef SIMON_KS_KEYCACHE_EN
                    if (replay && filled_q) begin
                        state_d = S_RUN;
                        rep_d   = 1'b1;
                        rev_d   = reverse;
                        idx_d   = reverse ? LAST_IDX : 5'd0;
                    end
`endif
                end
                S_RUN: begin
                    if (!hold) begin
                        w0_d = w1_q;
                        w1_d = w2_q;
                        w2_d = w3_q;
                        w3_d = knew;
                        if (at_last) begin
                            state_d = S_DONE;
`ifdef SIMON_KS_KEYCACHE_EN
                            if (!rep_q) filled_d = 1'b1;
`endif
                        end else begin
                            idx_d = idx_next;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            w0_q     <= '0;
            w1_q     <= '0;
            w2_q     <= '0;
            w3_q     <= '0;
            idx_q    <= '0;
`ifdef SIMON_KS_KEYCACHE_EN
            rep_q    <= 1'b0;
            rev_q    <= 1'b0;
            filled_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            w2_q     <= w2_d;
            w3_q     <= w3_d;
            idx_q    <= idx_d;
`ifdef SIMON_KS_KEYCACHE_EN
            rep_q    <= rep_d;
            rev_q    <= rev_d;
            filled_q <= filled_d;
`endif
        end
    end

`ifdef SIMON_KS_KEYCACHE_EN
    // Validity of the cache contents is tracked by filled_q, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (!reset && !start && state_q == S_RUN && !hold && !rep_q)
            cache_q[idx_q] <= w0_q;
    end
`endif

    assign run       = (state_q == S_RUN);
    assign round_key = run ? key_src : '0;
    assign round_idx = run ? idx_q : '0;
    assign key_valid = run;
    assign busy      = run;
    assign done      = (state_q == S_DONE);

endmodule
